// File: rtl/mips_defs.sv
// Shared MIPS32 decode constants for the ID/EX issue path.
// Holds ALU selector codes, opcode/funct encodings and default datapath widths.
// No ports; imported by id_ex_stage and operand_forward.
package mips_defs;

    localparam int DEF_BUS_SIZE = 32;
    localparam int DEF_REG_ADDR = 5;

    // ALU selector encodings
    localparam logic [2:0] ALU_SUM  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NONE = 3'b101;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    // R-type funct codes
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;

endpackage

// File: rtl/operand_forward.sv
// Purpose: per-source bypass mux picking EX/MEM, MEM/WB or register-file data.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: i_src source index, i_rf_data, EX/MEM and MEM/WB write info/data; o_data result.
module operand_forward
    import mips_defs::*;
#(
    parameter int BUS_SIZE = DEF_BUS_SIZE,
    parameter int REG_ADDR = DEF_REG_ADDR
) (
    input  logic [REG_ADDR-1:0] i_src,
    input  logic [BUS_SIZE-1:0] i_rf_data,
    input  logic                i_exmem_wr,
    input  logic [REG_ADDR-1:0] i_exmem_rd,
    input  logic [BUS_SIZE-1:0] i_exmem_data,
    input  logic                i_memwb_wr,
    input  logic [REG_ADDR-1:0] i_memwb_rd,
    input  logic [BUS_SIZE-1:0] i_memwb_data,
    output logic [BUS_SIZE-1:0] o_data
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    // $0 is never a bypass target: a producer "writing" $0 writes nothing.
    assign w_hit_exmem = i_exmem_wr && (i_exmem_rd != '0) && (i_exmem_rd == i_src);
    assign w_hit_memwb = i_memwb_wr && (i_memwb_rd != '0) && (i_memwb_rd == i_src);

    // The younger producer (EX/MEM) wins when both stages target the same register.
    assign o_data = w_hit_exmem ? i_exmem_data :
                    w_hit_memwb ? i_memwb_data : i_rf_data;

endmodule

// File: rtl/id_ex_stage.sv
// Purpose: decode MIPS32 ALU instructions, resolve forwarded operands, register into ID/EX latch.
// Latency: 1 cycle instr -> outputs, all outputs registered.
// Backpressure: stall holds the latch; flush or in_valid=0 loads a bubble.
// Ports: clk/reset (sync, active-high); instr + rs/rt data + EX/MEM, MEM/WB bypass inputs;
//        alu_a/alu_b/alu_sel/rd_out/reg_write/out_valid/illegal outputs.
module id_ex_stage
    import mips_defs::*;
#(
    parameter int BUS_SIZE = DEF_BUS_SIZE,
    parameter int REG_ADDR = DEF_REG_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                stall,
    input  logic                flush,
    input  logic [31:0]         instr,
    input  logic [BUS_SIZE-1:0] rs_data,
    input  logic [BUS_SIZE-1:0] rt_data,
    input  logic                exmem_wr,
    input  logic [REG_ADDR-1:0] exmem_rd,
    input  logic [BUS_SIZE-1:0] exmem_data,
    input  logic                memwb_wr,
    input  logic [REG_ADDR-1:0] memwb_rd,
    input  logic [BUS_SIZE-1:0] memwb_data,
    output logic [BUS_SIZE-1:0] alu_a,
    output logic [BUS_SIZE-1:0] alu_b,
    output logic [2:0]          alu_sel,
    output logic [REG_ADDR-1:0] rd_out,
    output logic                reg_write,
    output logic                out_valid,
    output logic                illegal
);

    logic [5:0]          w_op;
    logic [5:0]          w_funct;
    logic [2:0]          w_sel;
    logic [REG_ADDR-1:0] w_dest;
    logic                w_decoded;
    logic                w_use_imm;
    logic                w_sext;
    logic                w_illegal;
    logic [BUS_SIZE-1:0] w_imm;
    logic [BUS_SIZE-1:0] w_fwd_rs;
    logic [BUS_SIZE-1:0] w_fwd_rt;

    logic [BUS_SIZE-1:0] r_alu_a;
    logic [BUS_SIZE-1:0] r_alu_b;
    logic [2:0]          r_alu_sel;
    logic [REG_ADDR-1:0] r_rd;
    logic                r_reg_write;
    logic                r_valid;
    logic                r_illegal;

    assign w_op    = instr[31:26];
    assign w_funct = instr[5:0];

    operand_forward #(.BUS_SIZE(BUS_SIZE), .REG_ADDR(REG_ADDR)) u_fwd_rs (
        .i_src        (REG_ADDR'(instr[25:21])),
        .i_rf_data    (rs_data),
        .i_exmem_wr   (exmem_wr),
        .i_exmem_rd   (exmem_rd),
        .i_exmem_data (exmem_data),
        .i_memwb_wr   (memwb_wr),
        .i_memwb_rd   (memwb_rd),
        .i_memwb_data (memwb_data),
        .o_data       (w_fwd_rs)
    );

    operand_forward #(.BUS_SIZE(BUS_SIZE), .REG_ADDR(REG_ADDR)) u_fwd_rt (
        .i_src        (REG_ADDR'(instr[20:16])),
        .i_rf_data    (rt_data),
        .i_exmem_wr   (exmem_wr),
        .i_exmem_rd   (exmem_rd),
        .i_exmem_data (exmem_data),
        .i_memwb_wr   (memwb_wr),
        .i_memwb_rd   (memwb_rd),
        .i_memwb_data (memwb_data),
        .o_data       (w_fwd_rt)
    );

    always_comb begin
        w_sel     = ALU_NONE;
        w_dest    = REG_ADDR'(instr[20:16]);
        w_decoded = 1'b0;
        w_use_imm = 1'b0;
        w_sext    = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_dest = REG_ADDR'(instr[15:11]);
                w_decoded = 1'b1;
                case (w_funct)
                    F_ADD, F_ADDU: w_sel = ALU_SUM;
                    F_SUB, F_SUBU: w_sel = ALU_SUB;
                    F_AND:         w_sel = ALU_AND;
                    F_OR:          w_sel = ALU_OR;
                    F_XOR:         w_sel = ALU_XOR;
                    default:       w_decoded = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                w_sel = ALU_SUM; w_decoded = 1'b1; w_use_imm = 1'b1; w_sext = 1'b1;
            end
            OP_ANDI: begin
                w_sel = ALU_AND; w_decoded = 1'b1; w_use_imm = 1'b1;
            end
            OP_ORI: begin
                w_sel = ALU_OR;  w_decoded = 1'b1; w_use_imm = 1'b1;
            end
            OP_XORI: begin
                w_sel = ALU_XOR; w_decoded = 1'b1; w_use_imm = 1'b1;
            end
            default: ;
        endcase
    end

    // The all-zero word (sll $0,$0,0) is the canonical NOP: valid but not flagged.
    assign w_illegal = !w_decoded && (instr != 32'd0);

    assign w_imm = w_sext ? {{(BUS_SIZE-16){instr[15]}}, instr[15:0]}
                          : {{(BUS_SIZE-16){1'b0}}, instr[15:0]};

    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && !in_valid)) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= ALU_NONE;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!stall) begin
            r_alu_a     <= w_fwd_rs;
            r_alu_b     <= w_use_imm ? w_imm : w_fwd_rt;
            r_alu_sel   <= w_sel;
            r_rd        <= w_decoded ? w_dest : '0;
            r_reg_write <= w_decoded && (w_dest != '0);
            r_valid     <= 1'b1;
            r_illegal   <= w_illegal;
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign rd_out    = r_rd;
    assign reg_write = r_reg_write;
    assign out_valid = r_valid;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed vector table, hand-written stall/flush/reset
// sequences, then randomized traffic checked against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [31:0] instr, rs_data, rt_data, exmem_data, memwb_data;
    logic        exmem_wr, memwb_wr;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_sel;
    logic [4:0]  rd_out;
    logic        reg_write, out_valid, illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .rd_out(rd_out),
        .reg_write(reg_write), .out_valid(out_valid), .illegal(illegal)
    );

    // Expected latch contents; chk_ab marks whether operands/rd are defined.
    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  sel;
        logic [4:0]  rd;
        bit          rw, v, ill, chk_ab;
    } st_t;

    typedef struct {
        logic [31:0] instr, rs, rt;
        bit          exwr;
        logic [4:0]  exrd;
        logic [31:0] exd;
        bit          mwwr;
        logic [4:0]  mwrd;
        logic [31:0] mwd;
        logic [31:0] ea, eb;
        logic [2:0]  esel;
        logic [4:0]  erd;
        bit          erw, eill, chk_ab;
    } vec_t;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input st_t e);
        cmp({tag, ".out_valid"}, 32'(out_valid), 32'(e.v));
        cmp({tag, ".alu_sel"},   32'(alu_sel),   32'(e.sel));
        cmp({tag, ".reg_write"}, 32'(reg_write), 32'(e.rw));
        cmp({tag, ".illegal"},   32'(illegal),   32'(e.ill));
        if (e.chk_ab) begin
            cmp({tag, ".alu_a"},  alu_a,        e.a);
            cmp({tag, ".alu_b"},  alu_b,        e.b);
            cmp({tag, ".rd_out"}, 32'(rd_out),  32'(e.rd));
        end
    endtask

    function automatic st_t bubble();
        st_t s;
        s.a = 0; s.b = 0; s.sel = 3'b101; s.rd = 0;
        s.rw = 0; s.v = 0; s.ill = 0; s.chk_ab = 1;
        return s;
    endfunction

    task automatic idle_inputs();
        reset = 0; in_valid = 1; stall = 0; flush = 0;
        instr = 0; rs_data = 0; rt_data = 0;
        exmem_wr = 0; exmem_rd = 0; exmem_data = 0;
        memwb_wr = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------- behavioural reference model ----------
    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
        if (exmem_wr && exmem_rd != 0 && exmem_rd == src) return exmem_data;
        if (memwb_wr && memwb_rd != 0 && memwb_rd == src) return memwb_data;
        return rf;
    endfunction

    function automatic st_t ref_decode();
        st_t s;
        logic [5:0]  op, fn;
        logic [31:0] imm_z, imm_s;
        bit known;
        op = instr[31:26];
        fn = instr[5:0];
        imm_z = {16'h0000, instr[15:0]};
        imm_s = {{16{instr[15]}}, instr[15:0]};
        s = bubble();
        s.v = 1;
        known = 1;
        s.a = ref_fwd(instr[25:21], rs_data);
        if (op == 6'd0 && fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26}) begin
            s.sel = (fn == 6'h20 || fn == 6'h21) ? 3'd0 :
                    (fn == 6'h22 || fn == 6'h23) ? 3'd1 : 3'(fn - 6'h22);
            s.rd  = instr[15:11];
            s.b   = ref_fwd(instr[20:16], rt_data);
        end else if (op == 6'h08 || op == 6'h09) begin
            s.sel = 3'd0; s.rd = instr[20:16]; s.b = imm_s;
        end else if (op >= 6'h0C && op <= 6'h0E) begin
            s.sel = 3'(op - 6'h0A); s.rd = instr[20:16]; s.b = imm_z;
        end else begin
            known = 0;
        end
        if (known) begin
            s.rw = (s.rd != 0);
        end else begin
            s.sel = 3'b101; s.rw = 0; s.ill = (instr != 0); s.chk_ab = 0;
        end
        return s;
    endfunction

    function automatic st_t ref_next(input st_t cur);
        if (reset || flush) return bubble();
        if (stall) return cur;
        if (!in_valid) return bubble();
        return ref_decode();
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] rfun [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A};
        logic [5:0] iops [7] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h0A};
        logic [4:0] rs, rt, rd;
        int k;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 9);
        if (k < 5)  return {6'd0, rs, rt, rd, 5'd0, rfun[$urandom_range(0, 7)]};
        if (k < 8)  return {iops[$urandom_range(0, 6)], rs, rt, 16'($urandom)};
        if (k == 8) return 32'd0;
        return $urandom;
    endfunction

    vec_t vt [16];
    st_t  exp_s;

    initial begin
        // instr, rs, rt, exwr, exrd, exd, mwwr, mwrd, mwd, ea, eb, esel, erd, erw, eill, chk
        vt[0]  = '{32'h00221820, 5, 7, 0, 0, 0, 0, 0, 0, 5, 7, 3'd0, 3, 1, 0, 1};
        vt[1]  = '{32'h2024FFFF, 5, 7, 0, 0, 0, 0, 0, 0, 5, 32'hFFFFFFFF, 3'd0, 4, 1, 0, 1};
        vt[2]  = '{32'h34248000, 5, 7, 0, 0, 0, 0, 0, 0, 5, 32'h00008000, 3'd3, 4, 1, 0, 1};
        vt[3]  = '{32'h00222822, 5, 7, 1, 1, 32'hAA, 1, 1, 32'hBB, 32'hAA, 7, 3'd1, 5, 1, 0, 1};
        vt[4]  = '{32'h00222822, 5, 7, 1, 1, 32'hAA, 1, 2, 32'hBB, 32'hAA, 32'hBB, 3'd1, 5, 1, 0, 1};
        vt[5]  = '{32'h00222822, 5, 7, 1, 0, 32'hAA, 0, 0, 0, 5, 7, 3'd1, 5, 1, 0, 1};
        vt[6]  = '{32'h00223024, 5, 7, 0, 0, 0, 0, 0, 0, 5, 7, 3'd2, 6, 1, 0, 1};
        vt[7]  = '{32'h00223826, 9, 3, 0, 0, 0, 0, 0, 0, 9, 3, 3'd4, 7, 1, 0, 1};
        vt[8]  = '{32'h0022402A, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 0, 0, 1, 0};
        vt[9]  = '{32'h00220020, 5, 7, 0, 0, 0, 0, 0, 0, 5, 7, 3'd0, 0, 0, 0, 1};
        vt[10] = '{32'h00000000, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 0, 0, 0, 0};
        vt[11] = '{32'h3029F0F0, 5, 7, 0, 0, 0, 0, 0, 0, 5, 32'h0000F0F0, 3'd2, 9, 1, 0, 1};
        vt[12] = '{32'h382A8001, 5, 7, 0, 0, 0, 0, 0, 0, 5, 32'h00008001, 3'd4, 10, 1, 0, 1};
        vt[13] = '{32'h242B7FFF, 5, 7, 0, 0, 0, 0, 0, 0, 5, 32'h00007FFF, 3'd0, 11, 1, 0, 1};
        vt[14] = '{32'h8C220000, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 3'd5, 0, 0, 1, 0};
        vt[15] = '{32'h00221820, 5, 7, 0, 1, 32'hAA, 0, 2, 32'hBB, 5, 7, 3'd0, 3, 1, 0, 1};

        idle_inputs();

        // Reset dominates a valid add.
        reset = 1; instr = 32'h00221820; rs_data = 5; rt_data = 7;
        tick();
        check_state("reset", bubble());
        reset = 0;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            st_t e;
            instr = vt[i].instr; rs_data = vt[i].rs; rt_data = vt[i].rt;
            exmem_wr = vt[i].exwr; exmem_rd = vt[i].exrd; exmem_data = vt[i].exd;
            memwb_wr = vt[i].mwwr; memwb_rd = vt[i].mwrd; memwb_data = vt[i].mwd;
            tick();
            e.a = vt[i].ea; e.b = vt[i].eb; e.sel = vt[i].esel; e.rd = vt[i].erd;
            e.rw = vt[i].erw; e.v = 1; e.ill = vt[i].eill; e.chk_ab = vt[i].chk_ab;
            check_state($sformatf("vec%0d", i), e);
        end

        // Stall holds an 'and' for three cycles while inputs change.
        idle_inputs();
        instr = 32'h00223024; rs_data = 32'h11; rt_data = 32'h22;
        tick();
        exp_s = bubble();
        exp_s.a = 32'h11; exp_s.b = 32'h22; exp_s.sel = 3'd2; exp_s.rd = 6; exp_s.rw = 1; exp_s.v = 1;
        check_state("and_load", exp_s);
        stall = 1;
        for (int c = 0; c < 3; c++) begin
            instr = 32'h00223826 + 32'(c << 11); rs_data = 32'(c + 100); rt_data = 32'h55;
            tick();
            check_state($sformatf("stall%0d", c), exp_s);
        end

        // Illegal held through stall, then stall+flush yields a bubble.
        stall = 0; instr = 32'h0022402A;
        tick();
        exp_s = bubble(); exp_s.v = 1; exp_s.ill = 1; exp_s.chk_ab = 0;
        check_state("ill_load", exp_s);
        stall = 1; instr = 32'h00221820;
        tick();
        check_state("ill_stall", exp_s);
        flush = 1;
        tick();
        check_state("stall_flush", bubble());

        // Reset during stall clears a loaded instruction.
        stall = 0; flush = 0; instr = 32'h00221820;
        tick();
        stall = 1; reset = 1;
        tick();
        check_state("reset_in_stall", bubble());
        reset = 0; stall = 0; in_valid = 0;
        tick();
        check_state("invalid_bubble", bubble());

        // Randomized traffic against the model.
        idle_inputs();
        exp_s = bubble();
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 63) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            in_valid = ($urandom_range(0, 5) != 0);
            instr    = rand_instr();
            rs_data  = $urandom; rt_data = $urandom;
            exmem_wr = $urandom_range(0, 1); exmem_rd = 5'($urandom_range(0, 3)); exmem_data = $urandom;
            memwb_wr = $urandom_range(0, 1); memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom;
            exp_s = ref_next(exp_s);
            tick();
            check_state($sformatf("rnd%0d", n), exp_s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
